key_debounce_pulse: RTL and testbench
=====================================

// Module: key_debounce_pulse
// PURPOSE
//  Input conditioning stage for lab-board push-buttons and switches; feeds the registered d/rst
//  inputs of downstream synchronous logic (d_ff_r-style flip-flops, counters, FSMs).
//  Synchronises the asynchronous raw key_in, rejects bounce with a 4-state FSM and counter,
//  and produces a clean level plus single-cycle rise/fall pulses. Also keeps a wrapping count
//  of accepted presses.
// PARAMETERS
//  CNT_MAX      1_000_000  stable cycles required to accept a transition (10 ms @ 100 MHz); >=2
//  SYNC_STAGES  2          synchroniser flop count on key_in; >=2
//  PCNT_W       8          width of press_cnt
// PORTS
//  clk        in   1       system clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  key_in     in   1       raw asynchronous button level (1 = pressed)
//  key_level  out  1       debounced level, registered
//  key_rise   out  1       one-cycle pulse on accepted 0->1
//  key_fall   out  1       one-cycle pulse on accepted 1->0
//  busy       out  1       1 while FSM is in a CHK state
//  press_cnt  out  PCNT_W  number of accepted rises, modulo 2^PCNT_W
// BEHAVIOUR
//  Reset (rst=1 at posedge): sync chain all 0, state S_LOW, cnt=0, key_level=0, key_rise=0,
//   key_fall=0, busy=0, press_cnt=0. Reset overrides every other event, including mid-CHK.
//  Sync: ks = sync[SYNC_STAGES-1], a plain shift chain; only ks is used by the FSM.
//  Counter cnt: width $clog2(CNT_MAX), cleared on each CHK entry, +1 per CHK cycle.
//  FSM states and transitions (evaluated each posedge):
//   S_LOW:      ks=1 -> S_RISE_CHK, cnt<=0; else stay.
//   S_RISE_CHK: ks=0 -> S_LOW (glitch rejected, no pulse).
//               ks=1 & cnt==CNT_MAX-1 -> S_HIGH, key_rise<=1.
//               else cnt<=cnt+1.
//   S_HIGH:     ks=0 -> S_FALL_CHK, cnt<=0; else stay.
//   S_FALL_CHK: ks=1 -> S_HIGH (glitch rejected, no pulse).
//               ks=0 & cnt==CNT_MAX-1 -> S_LOW, key_fall<=1.
//               else cnt<=cnt+1.
//  Outputs:
//   key_level = 1 in S_HIGH and S_FALL_CHK; 0 in S_LOW and S_RISE_CHK (registered with state).
//   key_rise/key_fall are high for exactly one cycle, never simultaneously.
//   busy = 1 in either CHK state.
//  Latency: with E0 = first posedge sampling key_in=1, ks=1 after edge E(SYNC_STAGES-1);
//   state is RISE_CHK after E(SYNC_STAGES); key_rise and key_level are high after
//   E(SYNC_STAGES+CNT_MAX). Release is symmetric.
//  press_cnt: +1 on the same edge that sets key_rise; wraps 2^PCNT_W-1 -> 0.
//  A bounce inside a CHK state restarts detection from the origin stable state; cnt does not
//   carry over. Input stuck high through reset is accepted as a fresh press after release of rst.
// TESTING
//  T1 CNT_MAX=4, SYNC=2: rst 3 cycles, then key_in 0->1 held
//     -> key_rise=1 for one cycle after edge 6; key_level=1 from then; press_cnt=1.
//  T2 Bounce: key_in 1 for 2 cycles, 0 for 1, then 1 held
//     -> no pulse for the bounce; a single key_rise 6 edges after the final rise; press_cnt=1.
//  T3 Release of held key (key_in 1->0 held)
//     -> key_fall one cycle, 6 edges later; key_level=0; press_cnt unchanged.
//  T4 Glitch in S_HIGH: key_in low for 1 cycle
//     -> state returns to S_HIGH; key_fall never asserts; key_level stays 1.
//  T5 Wrap: 256 clean presses with PCNT_W=8
//     -> press_cnt reads 255 then 0; exactly 256 key_rise pulses seen.
//  T6 rst asserted while busy=1 in S_RISE_CHK
//     -> next cycle all outputs 0, state S_LOW; no stray key_rise after rst drops with key_in=0.

Source files
------------

// File: rtl/key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_pulse
// Description : Synchroniser + debounce FSM for a push-button, with a clean
//               level, one-cycle rise/fall pulses and a wrapping press count.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce_pulse #(
    parameter int unsigned CNT_MAX     = 1_000_000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    output logic              key_level,
    output logic              key_rise,
    output logic              key_fall,
    output logic              busy,
    output logic [PCNT_W-1:0] press_cnt
);

    localparam int unsigned c_CNT_W = $clog2(CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CNT_MAX - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [PCNT_W-1:0]  c_PCNT_ONE = PCNT_W'(1);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_RISE_CHK = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_FALL_CHK = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_busy;
    logic [PCNT_W-1:0]      r_pcnt;
    logic                   w_ks;

    assign w_ks = r_sync[SYNC_STAGES-1];

    // Outputs are updated on the same edge as the state they reflect, so
    // level/busy never lag the FSM by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
            r_pcnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], key_in};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_LOW: begin
                    if (w_ks) begin
                        r_state <= S_RISE_CHK;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RISE_CHK: begin
                    if (!w_ks) begin
                        r_state <= S_LOW;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_HIGH;
                        r_busy  <= 1'b0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                        r_pcnt  <= r_pcnt + c_PCNT_ONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!w_ks) begin
                        r_state <= S_FALL_CHK;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_FALL_CHK: begin
                    if (w_ks) begin
                        r_state <= S_HIGH;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= S_LOW;
                        r_busy  <= 1'b0;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_busy  <= 1'b0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign key_level = r_level;
    assign key_rise  = r_rise;
    assign key_fall  = r_fall;
    assign busy      = r_busy;
    assign press_cnt = r_pcnt;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce_pulse
// Description : Directed vector table plus press-count wrap sequence for
//               key_debounce_pulse (CNT_MAX=4, SYNC_STAGES=2, PCNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_pulse;

    typedef struct {
        logic       rst;
        logic       key;
        logic       lvl;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] pcnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_in = 1'b0;
    logic       key_level;
    logic       key_rise;
    logic       key_fall;
    logic       busy;
    logic [7:0] press_cnt;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_rise = 0;
    int   n_fall = 0;
    int   n_both = 0;

    key_debounce_pulse #(
        .CNT_MAX    (4),
        .SYNC_STAGES(2),
        .PCNT_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_level(key_level),
        .key_rise (key_rise),
        .key_fall (key_fall),
        .busy     (busy),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic push(input logic r, input logic k, input logic l,
                        input logic ri, input logic f, input logic b,
                        input logic [7:0] p);
        vec_t v;
        v.rst = r; v.key = k; v.lvl = l; v.rise = ri;
        v.fall = f; v.busy = b; v.pcnt = p;
        vecs.push_back(v);
    endtask

    task automatic pushn(input int n, input logic r, input logic k,
                         input logic l, input logic ri, input logic f,
                         input logic b, input logic [7:0] p);
        for (int i = 0; i < n; i++) push(r, k, l, ri, f, b, p);
    endtask

    // Drive inputs, take one edge, sample 1 time unit later.
    task automatic step(input logic r, input logic k);
        rst    = r;
        key_in = k;
        @(posedge clk);
        #1;
        if (key_rise) n_rise++;
        if (key_fall) n_fall++;
        if (key_rise && key_fall) n_both++;
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    initial begin
        // T1: clean press, rise after edge 6
        pushn(3, 1, 0, 0, 0, 0, 0, 0);
        pushn(2, 0, 1, 0, 0, 0, 0, 0);
        pushn(4, 0, 1, 0, 0, 0, 1, 0);
        push (   0, 1, 1, 1, 0, 0, 1);
        pushn(2, 0, 1, 1, 0, 0, 0, 1);
        // T2: bounce 1,1,0 then held high
        pushn(2, 1, 0, 0, 0, 0, 0, 0);
        pushn(2, 0, 1, 0, 0, 0, 0, 0);
        push (   0, 0, 0, 0, 0, 1, 0);
        push (   0, 1, 0, 0, 0, 1, 0);
        push (   0, 1, 0, 0, 0, 0, 0);
        pushn(4, 0, 1, 0, 0, 0, 1, 0);
        push (   0, 1, 1, 1, 0, 0, 1);
        push (   0, 1, 1, 0, 0, 0, 1);
        // T3: release
        pushn(2, 0, 0, 1, 0, 0, 0, 1);
        pushn(4, 0, 0, 1, 0, 0, 1, 1);
        push (   0, 0, 0, 0, 1, 0, 1);
        push (   0, 0, 0, 0, 0, 0, 1);
        // second press to reach S_HIGH
        pushn(2, 0, 1, 0, 0, 0, 0, 1);
        pushn(4, 0, 1, 0, 0, 0, 1, 1);
        push (   0, 1, 1, 1, 0, 0, 2);
        push (   0, 1, 1, 0, 0, 0, 2);
        // T4: one-cycle low glitch while high
        push (   0, 0, 1, 0, 0, 0, 2);
        push (   0, 1, 1, 0, 0, 0, 2);
        push (   0, 1, 1, 0, 0, 1, 2);
        pushn(6, 0, 1, 1, 0, 0, 0, 2);
        // T6: reset while in S_RISE_CHK
        push (   1, 0, 0, 0, 0, 0, 0);
        pushn(2, 0, 1, 0, 0, 0, 0, 0);
        pushn(2, 0, 1, 0, 0, 0, 1, 0);
        push (   1, 0, 0, 0, 0, 0, 0);
        pushn(7, 0, 0, 0, 0, 0, 0, 0);
        // key held through reset is a fresh press afterwards
        pushn(2, 1, 1, 0, 0, 0, 0, 0);
        pushn(2, 0, 1, 0, 0, 0, 0, 0);
        pushn(4, 0, 1, 0, 0, 0, 1, 0);
        push (   0, 1, 1, 1, 0, 0, 1);
        push (   0, 1, 1, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].key);
            n_vec++;
            if (key_level !== vecs[i].lvl || key_rise !== vecs[i].rise ||
                key_fall !== vecs[i].fall || busy !== vecs[i].busy ||
                press_cnt !== vecs[i].pcnt) begin
                n_miss++;
                $display("FAIL vec%0d: lvl/rise/fall/busy/pcnt got %b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
                         i, key_level, key_rise, key_fall, busy, press_cnt,
                         vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].busy, vecs[i].pcnt);
            end
        end

        // T5: 256 clean presses, press_cnt wraps 255 -> 0
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_int("wrap_start_pcnt", int'(press_cnt), 0);
        n_rise = 0;
        n_fall = 0;
        n_both = 0;
        for (int p = 0; p < 256; p++) begin
            for (int c = 0; c < 8; c++) step(1'b0, 1'b1);
            for (int c = 0; c < 8; c++) step(1'b0, 1'b0);
            if (p == 254) check_int("wrap_pcnt_255", int'(press_cnt), 255);
            if (p == 255) check_int("wrap_pcnt_0", int'(press_cnt), 0);
        end
        check_int("wrap_rise_pulses", n_rise, 256);
        check_int("wrap_fall_pulses", n_fall, 256);
        check_int("rise_fall_overlap", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
